// File: rtl/ps2_pkg.sv
// Shared PS/2 frame constants, receiver state encoding and the parity helper.
package ps2_pkg;

    localparam int unsigned   FRAME_BITS = 11;
    localparam logic [3:0]    START_IDX  = 4'd0;
    localparam logic [3:0]    PARITY_IDX = 4'd9;
    localparam logic [3:0]    STOP_IDX   = 4'(FRAME_BITS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } rx_state_t;

    // Odd parity: D0..D7 plus the parity bit must contain an odd number of ones.
    function automatic logic parity_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// Receive FIFO: power-of-two depth, combinational head read, push accepted when full if a pop coincides.
module ps2_rx_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == LW'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign level    = count;
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: line synchroniser, frame FSM with timeout, and receive FIFO.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned SYNC_STAGES    = 3,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              ps2_clk,
    input  logic                              ps2_data,
    input  logic                              ready,
    input  logic                              overflow_clr,
    output logic [7:0]                        data,
    output logic                              valid,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   level,
    output logic                              overflow,
    output logic                              parity_err,
    output logic                              frame_err,
    output logic                              timeout_err
);

    localparam int unsigned TW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-2:0] data_sync;
    logic                   fall;
    logic                   data_s;

    rx_state_t     state, state_n;
    logic [3:0]    bit_idx, idx_n;
    logic [8:0]    shreg, shreg_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic          push;
    logic          perr_n, ferr_n, terr_n;
    logic          full;
    logic          empty;

    // Data runs one stage shorter so its oldest flop lines up with the edge detector.
    assign fall   = clk_sync[SYNC_STAGES-1] && !clk_sync[SYNC_STAGES-2];
    assign data_s = data_sync[SYNC_STAGES-2];

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync  <= '1;
            data_sync <= '1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-3:0], ps2_data};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            bit_idx     <= START_IDX;
            shreg       <= '0;
            tcnt        <= '0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            bit_idx     <= idx_n;
            shreg       <= shreg_n;
            tcnt        <= tcnt_n;
            parity_err  <= perr_n;
            frame_err   <= ferr_n;
            timeout_err <= terr_n;
        end
    end

    // D0 enters first at the top, so after nine shifts shreg = {parity, D7..D0}.
    always_comb begin
        state_n = state;
        idx_n   = bit_idx;
        shreg_n = shreg;
        tcnt_n  = tcnt;
        push    = 1'b0;
        perr_n  = 1'b0;
        ferr_n  = 1'b0;
        terr_n  = 1'b0;
        if (fall) begin
            tcnt_n = '0;
            case (state)
                IDLE: begin
                    if (!data_s) begin
                        state_n = RECV;
                        idx_n   = START_IDX + 4'd1;
                    end
                end
                RECV: begin
                    if (bit_idx == STOP_IDX) begin
                        state_n = IDLE;
                        idx_n   = START_IDX;
                        if (!data_s) begin
                            ferr_n = 1'b1;
                        end else if (!parity_ok(shreg[7:0], shreg[8])) begin
                            perr_n = 1'b1;
                        end else begin
                            push = 1'b1;
                        end
                    end else begin
                        shreg_n = {data_s, shreg[8:1]};
                        idx_n   = bit_idx + 4'd1;
                    end
                end
                default: begin
                    state_n = IDLE;
                    idx_n   = START_IDX;
                end
            endcase
        end else if (state == RECV) begin
            if (tcnt == T_LAST) begin
                state_n = IDLE;
                idx_n   = START_IDX;
                tcnt_n  = '0;
                terr_n  = 1'b1;
            end else begin
                tcnt_n = tcnt + TW'(1);
            end
        end
    end

    ps2_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (shreg[7:0]),
        .pop       (ready),
        .pop_data  (data),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

    assign valid = !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (push && full && !(valid && ready)) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: frames, errors, overflow, timeout, glitch and reset recovery.
module tb_ps2_keyboard_rx;
    import ps2_pkg::*;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 200;
    localparam int          HALF    = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       ready = 1'b0;
    logic       overflow_clr = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic [2:0] level;
    logic       overflow;
    logic       parity_err;
    logic       frame_err;
    logic       timeout_err;

    int total = 0;
    int bad = 0;
    int perr_cnt = 0;
    int ferr_cnt = 0;
    int terr_cnt = 0;
    logic [7:0] popq[$];

    ps2_keyboard_rx #(
        .FIFO_DEPTH     (DEPTH),
        .SYNC_STAGES    (3),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .ready        (ready),
        .overflow_clr (overflow_clr),
        .data         (data),
        .valid        (valid),
        .level        (level),
        .overflow     (overflow),
        .parity_err   (parity_err),
        .frame_err    (frame_err),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (parity_err)  perr_cnt++;
        if (frame_err)   ferr_cnt++;
        if (timeout_err) terr_cnt++;
        if (valid && ready) popq.push_back(data);
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation still running at %0t, limit 2ms", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic pflip, input logic stop);
        logic p;
        p = ~(^d) ^ pflip;
        return {stop, p, d, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = f[i];
            tick(HALF);
            ps2_clk = 1'b0;
            tick(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        tick(HALF);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pflip, input logic stop);
        send_bits(mk_frame(d, pflip, stop), 11);
        tick(4);
    endtask

    // Leaves the bench inside the cycle where the DUT sees the stop-bit edge.
    task automatic send_to_stop_edge(input logic [7:0] d);
        send_bits(mk_frame(d, 1'b0, 1'b1), 10);
        ps2_data = 1'b1;
        tick(HALF);
        ps2_clk = 1'b0;
        tick(2);
    endtask

    task automatic drain();
        ready = 1'b1;
        tick(8);
        ready = 1'b0;
        tick(1);
    endtask

    task automatic clear_counts();
        perr_cnt = 0;
        ferr_cnt = 0;
        terr_cnt = 0;
        popq.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        total++; if (valid !== 1'b0)    begin bad++; $display("FAIL reset_valid: got %b expected 0", valid); end
        total++; if (level !== 3'd0)    begin bad++; $display("FAIL reset_level: got %0d expected 0", level); end
        total++; if (data !== 8'h00)    begin bad++; $display("FAIL reset_data: got %h expected 00", data); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        total++; if ({parity_err, frame_err, timeout_err} !== 3'b000)
            begin bad++; $display("FAIL reset_errs: got %b expected 000", {parity_err, frame_err, timeout_err}); end
        reset = 1'b0;
        tick(4);
        total++; if (level !== 3'd0)    begin bad++; $display("FAIL release_level: got %0d expected 0", level); end
    endtask

    task automatic test_single_frame();
        clear_counts();
        ready = 1'b0;
        send_frame(8'h1C, 1'b0, 1'b1);
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL single_valid: got %b expected 1", valid); end
        total++; if (data !== 8'h1C) begin bad++; $display("FAIL single_data: got %h expected 1c", data); end
        total++; if (level !== 3'd1) begin bad++; $display("FAIL single_level: got %0d expected 1", level); end
        tick(5);
        total++; if (data !== 8'h1C) begin bad++; $display("FAIL single_hold: got %h expected 1c", data); end
        total++; if (perr_cnt + ferr_cnt + terr_cnt != 0)
            begin bad++; $display("FAIL single_errs: got %0d expected 0", perr_cnt + ferr_cnt + terr_cnt); end
        drain();
        total++; if (level !== 3'd0) begin bad++; $display("FAIL single_drain: got %0d expected 0", level); end
    endtask

    task automatic test_latency();
        send_to_stop_edge(8'hA5);
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL latency_early: got %b expected 0", valid); end
        tick(1);
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL latency_valid: got %b expected 1", valid); end
        total++; if (data !== 8'hA5) begin bad++; $display("FAIL latency_data: got %h expected a5", data); end
        total++; if (level !== 3'd1) begin bad++; $display("FAIL latency_level: got %0d expected 1", level); end
        ps2_clk = 1'b1;
        tick(HALF);
        drain();
    endtask

    task automatic test_errors();
        clear_counts();
        send_frame(8'h1C, 1'b1, 1'b1);
        total++; if (perr_cnt != 1)  begin bad++; $display("FAIL parity_pulse: got %0d expected 1", perr_cnt); end
        total++; if (level !== 3'd0) begin bad++; $display("FAIL parity_level: got %0d expected 0", level); end
        clear_counts();
        send_frame(8'h1C, 1'b0, 1'b0);
        total++; if (ferr_cnt != 1)  begin bad++; $display("FAIL frame_pulse: got %0d expected 1", ferr_cnt); end
        total++; if (perr_cnt != 0)  begin bad++; $display("FAIL frame_noparity: got %0d expected 0", perr_cnt); end
        total++; if (level !== 3'd0) begin bad++; $display("FAIL frame_level: got %0d expected 0", level); end
        clear_counts();
        send_frame(8'h1C, 1'b1, 1'b0);
        total++; if (ferr_cnt != 1 || perr_cnt != 0)
            begin bad++; $display("FAIL both_bad: got ferr=%0d perr=%0d expected ferr=1 perr=0", ferr_cnt, perr_cnt); end
    endtask

    task automatic test_overflow();
        clear_counts();
        ready = 1'b0;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b1);
        total++; if (level !== 3'd4)    begin bad++; $display("FAIL ovf_level: got %0d expected 4", level); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b expected 1", overflow); end
        total++; if (data !== 8'h01)    begin bad++; $display("FAIL ovf_head: got %h expected 01", data); end
        drain();
        total++; if (popq.size() != 4) begin bad++; $display("FAIL ovf_count: got %0d expected 4", popq.size()); end
        for (int i = 0; i < popq.size() && i < 4; i++) begin
            total++;
            if (popq[i] !== 8'(i + 1)) begin bad++; $display("FAIL ovf_order[%0d]: got %h expected %h", i, popq[i], 8'(i + 1)); end
        end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
        overflow_clr = 1'b1;
        tick(1);
        overflow_clr = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
    endtask

    task automatic test_timeout();
        clear_counts();
        send_bits(mk_frame(8'h55, 1'b0, 1'b1), 5);
        tick(TIMEOUT - 20);
        total++; if (terr_cnt != 0) begin bad++; $display("FAIL timeout_early: got %0d expected 0", terr_cnt); end
        tick(40);
        total++; if (terr_cnt != 1) begin bad++; $display("FAIL timeout_pulse: got %0d expected 1", terr_cnt); end
        total++; if (dut.state !== IDLE) begin bad++; $display("FAIL timeout_state: got %0d expected IDLE", dut.state); end
        total++; if (level !== 3'd0) begin bad++; $display("FAIL timeout_level: got %0d expected 0", level); end
        send_frame(8'hF0, 1'b0, 1'b1);
        total++; if (data !== 8'hF0 || level !== 3'd1)
            begin bad++; $display("FAIL timeout_next: got %h/%0d expected f0/1", data, level); end
        drain();
    endtask

    task automatic test_glitch_and_reset();
        clear_counts();
        ps2_data = 1'b1;
        tick(HALF);
        ps2_clk = 1'b0;
        tick(HALF);
        ps2_clk = 1'b1;
        tick(HALF);
        total++; if (dut.state !== IDLE || dut.bit_idx !== 4'd0)
            begin bad++; $display("FAIL glitch_state: got %0d/%0d expected IDLE/0", dut.state, dut.bit_idx); end
        total++; if (perr_cnt + ferr_cnt + terr_cnt != 0)
            begin bad++; $display("FAIL glitch_pulses: got %0d expected 0", perr_cnt + ferr_cnt + terr_cnt); end
        send_bits(mk_frame(8'h77, 1'b0, 1'b1), 6);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(2);
        total++; if (dut.state !== IDLE) begin bad++; $display("FAIL midreset_state: got %0d expected IDLE", dut.state); end
        send_frame(8'h29, 1'b0, 1'b1);
        total++; if (data !== 8'h29 || level !== 3'd1)
            begin bad++; $display("FAIL midreset_next: got %h/%0d expected 29/1", data, level); end
        total++; if (perr_cnt + ferr_cnt + terr_cnt != 0)
            begin bad++; $display("FAIL midreset_errs: got %0d expected 0", perr_cnt + ferr_cnt + terr_cnt); end
        drain();
    endtask

    task automatic test_back_to_back();
        clear_counts();
        ready = 1'b0;
        for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b0, 1'b1);
        total++; if (level !== 3'd4) begin bad++; $display("FAIL full_level: got %0d expected 4", level); end
        send_to_stop_edge(8'h14);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        total++; if (level !== 3'd4)    begin bad++; $display("FAIL pushpop_level: got %0d expected 4", level); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL pushpop_ovf: got %b expected 0", overflow); end
        total++; if (data !== 8'h11)    begin bad++; $display("FAIL pushpop_head: got %h expected 11", data); end
        ps2_clk = 1'b1;
        tick(HALF);
        drain();
        total++; if (popq.size() != 5) begin bad++; $display("FAIL pushpop_count: got %0d expected 5", popq.size()); end
        for (int i = 0; i < popq.size() && i < 5; i++) begin
            total++;
            if (popq[i] !== 8'h10 + 8'(i)) begin bad++; $display("FAIL pushpop_order[%0d]: got %h expected %h", i, popq[i], 8'h10 + 8'(i)); end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_latency();
        test_errors();
        test_overflow();
        test_timeout();
        test_glitch_and_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
